// File: rtl/quant_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// quant_ctrl_pkg
//   Shared constants and types for the quantizer drain controller.
//   Holds the lane/width geometry, the signed clamp limits derived from the
//   quantized output width, the popcount width used for per-row clip counts,
//   and the controller state encoding.
// ---------------------------------------------------------------------------
package quant_ctrl_pkg;

    localparam int ARRAY_SIZE  = 16;
    localparam int ORI_WIDTH   = 29;
    localparam int OUT_WIDTH   = 16;
    localparam int ADDR_WIDTH  = 10;
    localparam int SHIFT_WIDTH = 5;
    localparam int SAT_WIDTH   = 16;

    // Signed clamp limits of the quantized lane.
    localparam int OUT_MAX = (2 ** (OUT_WIDTH - 1)) - 1;
    localparam int OUT_MIN = -(2 ** (OUT_WIDTH - 1));

    // Enough bits to count every lane of one row as clipped.
    localparam int POP_WIDTH = $clog2(ARRAY_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/quant_drain_ctrl_if.sv
// ---------------------------------------------------------------------------
// quant_drain_ctrl_if
//   Bundles the job-control, array-input and SRAM-write signals of the drain
//   controller.
//   Control : start, cfg_base_addr, cfg_num_rows, cfg_shift -> busy, done, sat_count
//   Input   : in_valid, in_data -> in_ready
//   Write   : wr_en, wr_addr, wr_data -> wr_ready
//   The slave modport is the controller; the master modport is whatever
//   drives it (top-level controller, array and SRAM, or a testbench).
// ---------------------------------------------------------------------------
interface quant_drain_ctrl_if;
    import quant_ctrl_pkg::*;

    logic                             start;
    logic [ADDR_WIDTH-1:0]            cfg_base_addr;
    logic [ADDR_WIDTH-1:0]            cfg_num_rows;
    logic [SHIFT_WIDTH-1:0]           cfg_shift;
    logic                             busy;
    logic                             done;
    logic [SAT_WIDTH-1:0]             sat_count;

    logic                             in_valid;
    logic                             in_ready;
    logic [ARRAY_SIZE*ORI_WIDTH-1:0]  in_data;

    logic                             wr_en;
    logic                             wr_ready;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [ARRAY_SIZE*OUT_WIDTH-1:0]  wr_data;

    modport slave (
        input  start, cfg_base_addr, cfg_num_rows, cfg_shift,
        output busy, done, sat_count,
        input  in_valid, in_data,
        output in_ready,
        output wr_en, wr_addr, wr_data,
        input  wr_ready
    );

    modport master (
        output start, cfg_base_addr, cfg_num_rows, cfg_shift,
        input  busy, done, sat_count,
        output in_valid, in_data,
        input  in_ready,
        input  wr_en, wr_addr, wr_data,
        output wr_ready
    );

endinterface

// File: rtl/quant_lane_sat.sv
// ---------------------------------------------------------------------------
// quant_lane_sat
//   Combinational single-lane quantizer: arithmetic right shift (floor) of a
//   signed accumulator followed by a signed clamp to the output width.
//   i_x       : signed accumulator lane
//   i_shift   : right-shift amount
//   o_y       : quantized lane
//   o_clipped : high when the clamp changed the value
// ---------------------------------------------------------------------------
module quant_lane_sat
    import quant_ctrl_pkg::*;
(
    input  logic signed [ORI_WIDTH-1:0]   i_x,
    input  logic        [SHIFT_WIDTH-1:0] i_shift,
    output logic        [OUT_WIDTH-1:0]   o_y,
    output logic                          o_clipped
);

    localparam logic signed [ORI_WIDTH-1:0] LIM_MAX = ORI_WIDTH'(OUT_MAX);
    localparam logic signed [ORI_WIDTH-1:0] LIM_MIN = ORI_WIDTH'(OUT_MIN);

    logic signed [ORI_WIDTH-1:0] w_shifted;

    // Arithmetic shift keeps the sign, so negative values round toward -inf.
    assign w_shifted = i_x >>> i_shift;

    // Clamp the shifted value into the signed output range; in-range values
    // simply drop their redundant sign bits.
    always_comb begin
        o_y       = w_shifted[OUT_WIDTH-1:0];
        o_clipped = 1'b0;
        if (w_shifted > LIM_MAX) begin
            o_y       = LIM_MAX[OUT_WIDTH-1:0];
            o_clipped = 1'b1;
        end else if (w_shifted < LIM_MIN) begin
            o_y       = LIM_MIN[OUT_WIDTH-1:0];
            o_clipped = 1'b1;
        end
    end

endmodule

// File: rtl/quant_drain_ctrl.sv
// ---------------------------------------------------------------------------
// quant_drain_ctrl
//   Drains systolic-array result rows through per-lane shift-and-saturate
//   quantizers into the output SRAM, one row per cycle when the SRAM keeps up.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of quant_drain_ctrl_if (job control, array input
//           handshake, SRAM write handshake)
//   A single output register stage holds each quantized row until the SRAM
//   accepts it; a new row may be captured in the same cycle the held row is
//   written.
// ---------------------------------------------------------------------------
module quant_drain_ctrl
    import quant_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    quant_drain_ctrl_if.slave  bus
);

    state_t                          r_state;
    state_t                          w_next_state;

    logic [ADDR_WIDTH-1:0]           r_base;
    logic [ADDR_WIDTH-1:0]           r_rows_left;
    logic [ADDR_WIDTH-1:0]           r_row_idx;
    logic [SHIFT_WIDTH-1:0]          r_shift;
    logic [SAT_WIDTH-1:0]            r_sat_count;

    logic                            r_wr_en;
    logic [ADDR_WIDTH-1:0]           r_wr_addr;
    logic [ARRAY_SIZE*OUT_WIDTH-1:0] r_wr_data;

    logic                            w_launch;
    logic                            w_in_ready;
    logic                            w_accept;
    logic                            w_wr_fire;
    logic [ARRAY_SIZE-1:0]           w_clipped;
    logic [ARRAY_SIZE*OUT_WIDTH-1:0] w_quant;
    logic [POP_WIDTH-1:0]            w_clip_cnt;
    logic [SAT_WIDTH:0]              w_sat_sum;
    logic [SAT_WIDTH-1:0]            w_sat_next;

    assign w_launch   = (r_state == IDLE) && bus.start;
    assign w_wr_fire  = r_wr_en && bus.wr_ready;
    // The output stage can take a row when it is empty or being emptied now.
    assign w_in_ready = (r_state == RUN) && (r_rows_left != '0) &&
                        (!r_wr_en || bus.wr_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    generate
        for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
            quant_lane_sat u_lane (
                .i_x       (bus.in_data[g*ORI_WIDTH +: ORI_WIDTH]),
                .i_shift   (r_shift),
                .o_y       (w_quant[g*OUT_WIDTH +: OUT_WIDTH]),
                .o_clipped (w_clipped[g])
            );
        end
    endgenerate

    // Count clipped lanes of the incoming row and add them to the job total,
    // sticking at all-ones instead of wrapping.
    always_comb begin
        w_clip_cnt = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            w_clip_cnt = w_clip_cnt + POP_WIDTH'(w_clipped[i]);
        end
        w_sat_sum  = {1'b0, r_sat_count} + (SAT_WIDTH+1)'(w_clip_cnt);
        w_sat_next = w_sat_sum[SAT_WIDTH] ? '1 : w_sat_sum[SAT_WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // RUN ends only once every row has been accepted and the output stage
    // is empty or draining this cycle; DONE lasts exactly one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if ((r_rows_left == '0) && (!r_wr_en || bus.wr_ready)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Job configuration, row bookkeeping and clip accumulation. A launch
    // snapshots the configuration so later cfg_* changes cannot disturb the
    // running job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_rows_left <= '0;
            r_row_idx   <= '0;
            r_shift     <= '0;
            r_sat_count <= '0;
        end else if (w_launch) begin
            r_base      <= bus.cfg_base_addr;
            r_rows_left <= bus.cfg_num_rows;
            r_row_idx   <= '0;
            r_shift     <= bus.cfg_shift;
            r_sat_count <= '0;
        end else if (w_accept) begin
            r_rows_left <= r_rows_left - 1'b1;
            r_row_idx   <= r_row_idx + 1'b1;
            r_sat_count <= w_sat_next;
        end
    end

    // Output register stage. A fresh row overwrites the stage only when it
    // is empty or being written this cycle, so a stalled row never changes.
    // The address adds naturally modulo the SRAM depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_base + r_row_idx;
            r_wr_data <= w_quant;
        end else if (w_wr_fire) begin
            r_wr_en   <= 1'b0;
        end
    end

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.sat_count = r_sat_count;
    assign bus.in_ready  = w_in_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;

endmodule

// File: tb/tb_quant_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_quant_drain_ctrl
//   Directed bench for quant_drain_ctrl. Inputs change on the falling edge
//   and outputs are sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_quant_drain_ctrl;
    import quant_ctrl_pkg::*;

    logic clk;
    logic rst_n;

    quant_drain_ctrl_if bus ();

    quant_drain_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [ARRAY_SIZE*ORI_WIDTH-1:0] rowData [8];
    logic [ADDR_WIDTH-1:0]           wrAddr  [8];
    logic [ARRAY_SIZE*OUT_WIDTH-1:0] wrData  [8];
    int                              wrCycle [8];
    int nWrites;
    int doneCycle;
    int busyCycles;
    int wrEnCycles;
    int stallViol;
    logic doneBusy;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Place one signed accumulator value into a lane of a stored row.
    task automatic setLane(input int row, input int lane, input int value);
        rowData[row][lane*ORI_WIDTH +: ORI_WIDTH] = ORI_WIDTH'(value);
    endtask

    // Launch a job, feed rows as fast as the DUT takes them with wr_ready
    // following a 4-cycle pattern, and record every SRAM write until done.
    // A second start with different config can be injected at restartCycle.
    task automatic run_job(input int rows, input logic [ADDR_WIDTH-1:0] base,
                           input logic [SHIFT_WIDTH-1:0] shift,
                           input logic [3:0] readyPat, input int restartCycle);
        int accepted;
        logic prevStall;
        logic [ADDR_WIDTH-1:0] prevAddr;
        logic [ARRAY_SIZE*OUT_WIDTH-1:0] prevData;
        nWrites = 0; doneCycle = -1; busyCycles = 0; wrEnCycles = 0;
        stallViol = 0; doneBusy = 1'b1; accepted = 0; prevStall = 1'b0;
        prevAddr = '0; prevData = '0;
        @(negedge clk);
        bus.start         = 1'b1;
        bus.cfg_base_addr = base;
        bus.cfg_num_rows  = ADDR_WIDTH'(rows);
        bus.cfg_shift     = shift;
        @(negedge clk);
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            bus.start    = 1'b0;
            bus.wr_ready = readyPat[c % 4];
            if (c == restartCycle) begin
                bus.start         = 1'b1;
                bus.cfg_base_addr = 10'h200;
                bus.cfg_num_rows  = 10'd5;
                bus.cfg_shift     = 5'd3;
            end
            if (accepted < rows) begin
                bus.in_valid = 1'b1;
                bus.in_data  = rowData[accepted];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = {ARRAY_SIZE{29'h0F0F0F0F}};
            end
            #1;
            if (bus.busy) busyCycles++;
            if (bus.wr_en) wrEnCycles++;
            if (prevStall && (!bus.wr_en || bus.wr_addr !== prevAddr ||
                              bus.wr_data !== prevData)) stallViol++;
            if (bus.wr_en && !bus.wr_ready && bus.in_ready) stallViol++;
            if (bus.wr_en && bus.wr_ready) begin
                if (nWrites < 8) begin
                    wrAddr[nWrites]  = bus.wr_addr;
                    wrData[nWrites]  = bus.wr_data;
                    wrCycle[nWrites] = c;
                end
                nWrites++;
            end
            prevStall = bus.wr_en && !bus.wr_ready;
            prevAddr  = bus.wr_addr;
            prevData  = bus.wr_data;
            if (bus.in_valid && bus.in_ready) accepted++;
            if (bus.done) begin
                doneCycle = c;
                doneBusy  = bus.busy;
                break;
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b0;
    endtask

    // Outputs must all be zero while reset is held, even with a valid row.
    task automatic test_reset();
        rst_n = 1'b1;
        bus.start = 1'b0; bus.cfg_base_addr = '0; bus.cfg_num_rows = '0;
        bus.cfg_shift = '0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.wr_ready = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.wr_ready = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.in_ready, bus.wr_en} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl busy/done/in_ready/wr_en=%b expected 0000",
                     {bus.busy, bus.done, bus.in_ready, bus.wr_en});
        end
        vectors++;
        if (bus.wr_addr !== '0 || bus.wr_data !== '0 || bus.sat_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data wr_addr=%h sat_count=%h expected 0",
                     bus.wr_addr, bus.sat_count);
        end
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Four rows across the address wrap, SRAM always ready.
    task automatic test_wrap_burst();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < ARRAY_SIZE; i++) setLane(r, i, 256 * (r*16 + i));
        run_job(4, 10'h3FE, 5'd8, 4'hF, -1);
        vectors++;
        if (doneCycle !== 5) begin
            miscompares++;
            $display("[TB] FAIL burst_done_cycle got %0d expected 5", doneCycle);
        end
        vectors++;
        if (nWrites !== 4) begin
            miscompares++;
            $display("[TB] FAIL burst_writes got %0d expected 4", nWrites);
        end
        if (nWrites == 4) begin
            vectors++;
            if (wrAddr[0] !== 10'h3FE || wrAddr[1] !== 10'h3FF ||
                wrAddr[2] !== 10'h000 || wrAddr[3] !== 10'h001) begin
                miscompares++;
                $display("[TB] FAIL burst_addr got %h %h %h %h expected 3fe 3ff 000 001",
                         wrAddr[0], wrAddr[1], wrAddr[2], wrAddr[3]);
            end
            vectors++;
            if (wrCycle[0] !== 1 || wrCycle[3] !== 4) begin
                miscompares++;
                $display("[TB] FAIL burst_timing first=%0d last=%0d expected 1 4",
                         wrCycle[0], wrCycle[3]);
            end
            for (int r = 0; r < 4; r++)
                for (int i = 0; i < ARRAY_SIZE; i++) begin
                    vectors++;
                    if (wrData[r][i*OUT_WIDTH +: OUT_WIDTH] !== 16'(r*16 + i)) begin
                        miscompares++;
                        $display("[TB] FAIL burst_lane r%0d l%0d got %h expected %h", r, i,
                                 wrData[r][i*OUT_WIDTH +: OUT_WIDTH], 16'(r*16 + i));
                    end
                end
        end
        vectors++;
        if (busyCycles !== 5 || doneBusy !== 1'b0 || wrEnCycles !== 4) begin
            miscompares++;
            $display("[TB] FAIL burst_flags busy=%0d doneBusy=%b wrEn=%0d expected 5 0 4",
                     busyCycles, doneBusy, wrEnCycles);
        end
        vectors++;
        if (bus.sat_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL burst_sat got %0d expected 0", bus.sat_count);
        end
    endtask

    // Both clamp directions plus exact limits that must not count as clipped.
    task automatic test_saturate();
        for (int i = 0; i < ARRAY_SIZE; i++) setLane(0, i, 0);
        setLane(0, 0, 40000);
        setLane(0, 1, -40000);
        setLane(0, 2, 32767);
        setLane(0, 3, -32768);
        setLane(0, 4, 1234);
        run_job(1, 10'h055, 5'd0, 4'hF, -1);
        vectors++;
        if (nWrites !== 1 || doneCycle !== 2) begin
            miscompares++;
            $display("[TB] FAIL sat_job writes=%0d done=%0d expected 1 2", nWrites, doneCycle);
        end
        vectors++;
        if (wrAddr[0] !== 10'h055 || wrData[0][5*OUT_WIDTH-1:0] !==
            {16'd1234, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}) begin
            miscompares++;
            $display("[TB] FAIL sat_lanes addr=%h lanes4..0=%h expected 055 04d280007fff80007fff",
                     wrAddr[0], wrData[0][5*OUT_WIDTH-1:0]);
        end
        vectors++;
        if (bus.sat_count !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL sat_count got %0d expected 2", bus.sat_count);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.sat_count !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL sat_hold got %0d expected 2", bus.sat_count);
        end
    endtask

    // SRAM ready every other cycle: the held row must not move or repeat.
    task automatic test_stall();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < ARRAY_SIZE; i++) setLane(r, i, 100*r + i);
        run_job(3, 10'h120, 5'd0, 4'b0101, -1);
        vectors++;
        if (nWrites !== 3 || doneCycle !== 7 || wrEnCycles !== 6) begin
            miscompares++;
            $display("[TB] FAIL stall_count writes=%0d done=%0d wrEn=%0d expected 3 7 6",
                     nWrites, doneCycle, wrEnCycles);
        end
        vectors++;
        if (stallViol !== 0) begin
            miscompares++;
            $display("[TB] FAIL stall_stability violations=%0d expected 0", stallViol);
        end
        if (nWrites == 3) begin
            for (int r = 0; r < 3; r++) begin
                vectors++;
                if (wrAddr[r] !== 10'(10'h120 + r) ||
                    wrData[r][15*OUT_WIDTH +: OUT_WIDTH] !== 16'(100*r + 15)) begin
                    miscompares++;
                    $display("[TB] FAIL stall_row%0d addr=%h lane15=%0d expected %h %0d", r,
                             wrAddr[r], wrData[r][15*OUT_WIDTH +: OUT_WIDTH],
                             10'(10'h120 + r), 100*r + 15);
                end
            end
        end
    endtask

    // Zero-row job, start during DONE, and start while busy.
    task automatic test_zero_and_restart();
        run_job(0, 10'h100, 5'd0, 4'hF, 1);
        vectors++;
        if (doneCycle !== 1 || busyCycles !== 1 || wrEnCycles !== 0 || nWrites !== 0) begin
            miscompares++;
            $display("[TB] FAIL zero_rows done=%0d busy=%0d wrEn=%0d writes=%0d expected 1 1 0 0",
                     doneCycle, busyCycles, wrEnCycles, nWrites);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_in_done busy=%b expected 0", bus.busy);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < ARRAY_SIZE; i++) setLane(r, i, 8*i + 1 + r);
        run_job(2, 10'h010, 5'd0, 4'hF, 1);
        vectors++;
        if (nWrites !== 2 || doneCycle !== 3) begin
            miscompares++;
            $display("[TB] FAIL restart_job writes=%0d done=%0d expected 2 3", nWrites, doneCycle);
        end
        if (nWrites == 2) begin
            vectors++;
            if (wrAddr[0] !== 10'h010 || wrAddr[1] !== 10'h011 ||
                wrData[1][7*OUT_WIDTH +: OUT_WIDTH] !== 16'd58) begin
                miscompares++;
                $display("[TB] FAIL restart_cfg addr=%h %h lane7=%0d expected 010 011 58",
                         wrAddr[0], wrAddr[1], wrData[1][7*OUT_WIDTH +: OUT_WIDTH]);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL restart_idle busy=%b expected 0", bus.busy);
        end
    endtask

    // Reset asserted while row 2 of 5 is in flight, then a clean job.
    task automatic test_reset_midjob();
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < ARRAY_SIZE; i++) setLane(r, i, i + 1);
        setLane(0, 0, 70000);
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_base_addr = 10'h020;
        bus.cfg_num_rows = 10'd5; bus.cfg_shift = 5'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.wr_ready = 1'b1;
            bus.in_valid = 1'b1; bus.in_data = rowData[c];
        end
        #1;
        vectors++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'h021 || bus.sat_count !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL midjob_pre wr_en=%b addr=%h sat=%0d expected 1 021 1",
                     bus.wr_en, bus.wr_addr, bus.sat_count);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.in_ready, bus.wr_en} !== 4'b0000 ||
            bus.wr_addr !== '0 || bus.wr_data !== '0 || bus.sat_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL midjob_reset flags=%b addr=%h sat=%0d expected 0000 000 0",
                     {bus.busy, bus.done, bus.in_ready, bus.wr_en}, bus.wr_addr, bus.sat_count);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midjob_nodone done=%b busy=%b expected 0 0",
                         bus.done, bus.busy);
            end
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        run_job(2, 10'h040, 5'd0, 4'hF, -1);
        vectors++;
        if (nWrites !== 2 || doneCycle !== 3 || bus.sat_count !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL rerun_job writes=%0d done=%0d sat=%0d expected 2 3 1",
                     nWrites, doneCycle, bus.sat_count);
        end
        if (nWrites == 2) begin
            vectors++;
            if (wrAddr[0] !== 10'h040 || wrAddr[1] !== 10'h041 ||
                wrData[0][0 +: OUT_WIDTH] !== 16'h7FFF ||
                wrData[1][3*OUT_WIDTH +: OUT_WIDTH] !== 16'd4) begin
                miscompares++;
                $display("[TB] FAIL rerun_data addr=%h %h lane0=%h expected 040 041 7fff",
                         wrAddr[0], wrAddr[1], wrData[0][0 +: OUT_WIDTH]);
            end
        end
    endtask

    // Maximum shift: any negative value floors to -1, any positive to 0.
    task automatic test_max_shift();
        for (int i = 0; i < ARRAY_SIZE; i++) setLane(0, i, 0);
        setLane(0, 0, -1);
        setLane(0, 1, 5);
        setLane(0, 2, -(2 ** 28));
        setLane(0, 3, (2 ** 28) - 1);
        run_job(1, 10'h3FF, 5'd31, 4'hF, -1);
        vectors++;
        if (nWrites !== 1 || wrAddr[0] !== 10'h3FF ||
            wrData[0][4*OUT_WIDTH-1:0] !== {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}) begin
            miscompares++;
            $display("[TB] FAIL shift31 writes=%0d addr=%h lanes3..0=%h expected 1 3ff 0000ffff0000ffff",
                     nWrites, wrAddr[0], wrData[0][4*OUT_WIDTH-1:0]);
        end
        vectors++;
        if (bus.sat_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL shift31_sat got %0d expected 0", bus.sat_count);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_wrap_burst();
        test_saturate();
        test_stall();
        test_zero_and_restart();
        test_reset_midjob();
        test_max_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
